nibble_serial_compare_ctrl: RTL and testbench
=============================================

Name: nibble_serial_compare_ctrl

Overview:
- Sequencing controller that compares two WIDTH-bit unsigned operands using one 4-bit magnitude-compare slice, one nibble per cycle, MSB nibble first.
- Stops early at the first unequal nibble.
- Sits between an upstream producer and a downstream consumer, with valid/ready handshakes on both sides.
- Lets the design reuse a 4-bit comparator for wide operands instead of instantiating a full-width comparator.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived nibble count; localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  upstream operands valid.
- in_ready  output  1  controller can accept operands.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- A_eq_B  output  1  A = B.
- A_gt_B  output  1  A > B.
- A_lt_B  output  1  A < B.
- busy  output  1  high in COMPARE or DONE.

Behaviour:
- Reset: while rst_n = 0, state goes to IDLE, nibble counter to 0, and operand shift registers to 0. Outputs during reset: A_eq_B/A_gt_B/A_lt_B = 0, out_valid = 0, busy = 0, in_ready = 0. in_ready rises in the first cycle after rst_n deasserts.
- FSM states:
  - IDLE: in_ready = 1. When in_valid & in_ready, capture A and B into shift registers, clear the counter, and go to COMPARE.
  - COMPARE: apply the top nibble of each shift register to the slice.
    - Slice reports unequal: register the slice flags, go to DONE.
    - Slice reports equal and counter = NIB-1: register eq = 1, go to DONE.
    - Otherwise: shift both registers left by 4, increment the counter, stay in COMPARE.
  - DONE: out_valid = 1 and flags held stable. When out_ready is high, go to IDLE. Back-to-back acceptance is not allowed: in_ready = 0 in DONE.
- Latency: with the accept edge as T0, and k = index (0 = MSB) of the first differing nibble, or NIB-1 if all nibbles are equal:
  - out_valid rises k+1 cycles after T0.
  - Minimum 1 cycle; maximum NIB cycles (4 for WIDTH = 16).
- Result flags:
  - Exactly one flag is high whenever out_valid = 1.
  - Flags keep their last result after the DONE→IDLE handshake; consumers qualify them with out_valid.
- Inputs are sampled only at acceptance. Changes on A/B/in_valid during COMPARE or DONE have no effect.
- in_valid may be asserted in the cycle out_valid drops; it is accepted on the next IDLE cycle.
- out_ready held high during COMPARE: result still presents for at least one cycle in DONE.
- Asynchronous reset mid-COMPARE or mid-DONE aborts the operation and clears all outputs. The pending result is lost; no partial result is emitted.
- Counter width: $clog2(NIB), minimum 1 bit. The counter never wraps, because COMPARE always exits at NIB-1.

Decomposition:
- Shared package: state encoding enum (IDLE, COMPARE, DONE) and a 3-bit one-hot result typedef {gt, eq, lt}.
- Sub-module nibble_cmp4:
  - Purely combinational 4-bit unsigned compare.
  - Outputs eq/gt/lt, exactly one high.
  - Instantiated once in the controller.
- The controller holds the FSM, counter, shift registers and result register.

Test Plan:
- Reset then A = 16'h1234, B = 16'h1234, out_ready = 1 → in_ready = 1 after reset; out_valid 4 cycles after accept; A_eq_B = 1, others 0.
- A = 16'h9000, B = 16'h8FFF → out_valid 1 cycle after accept; A_gt_B = 1; the remaining nibbles are never examined.
- A = 16'h12A4, B = 16'h12B0 → out_valid 3 cycles after accept; A_lt_B = 1.
- Backpressure: A = 16'h0001, B = 16'h0000, out_ready = 0 for 5 cycles → out_valid and A_gt_B stay 1 and stable while in_ready stays 0; idle one cycle after out_ready = 1.
- Operands change during COMPARE (A = 16'hFFFF→16'h0000 mid-op, original A = 16'h00F0, B = 16'h00F1) → the result still reflects the captured values: A_lt_B = 1.
- rst_n pulsed low during COMPARE of 16'h5555 vs 16'h5556 → all outputs 0 immediately; no out_valid is produced; a following 16'h0003 vs 16'h0003 compares correctly with eq = 1.

Source files
------------

// File: rtl/nibble_serial_compare_ctrl_pkg.sv
// Shared types for the nibble-serial magnitude compare controller.
// Contents: FSM state encoding, one-hot result type {gt, eq, lt}, slice width
// and a helper that sizes the nibble counter.
package nibble_serial_compare_ctrl_pkg;

  // Width of the single magnitude-compare slice reused for every nibble.
  localparam int NIB_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Registered result. It is exactly one-hot whenever a result is presented,
  // and it is all-zero only after reset.
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } res_t;

  localparam res_t RES_NONE = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};
  localparam res_t RES_EQ   = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};

  // Nibble counter width. It must index 0..nib-1, and it is never narrower
  // than one bit, so that a single-nibble configuration still elaborates.
  function automatic int cnt_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_compare_ctrl_if.sv
// Handshake and data bundle between producer/consumer and the compare controller.
// Ports: in_valid/in_ready/A/B (operand side), out_valid/out_ready (result side),
//        A_eq_B/A_gt_B/A_lt_B result flags, busy status.
interface nibble_serial_compare_ctrl_if #(
  parameter int WIDTH = 16
);
  import nibble_serial_compare_ctrl_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic             A_eq_B;
  logic             A_gt_B;
  logic             A_lt_B;
  logic             busy;

  // The master side is the environment. It supplies operands and consumes
  // results.
  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, A_eq_B, A_gt_B, A_lt_B, busy
  );

  // The slave side is the compare controller.
  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, A_eq_B, A_gt_B, A_lt_B, busy
  );

endinterface

// File: rtl/nibble_cmp4.sv
// 4-bit unsigned magnitude compare slice. It is purely combinational.
// Latency: 0 cycles. Backpressure: none, because this is a combinational leaf.
// Ports: a_i/b_i nibble operands; eq_o/gt_o/lt_o are exactly one-hot.
module nibble_cmp4
  import nibble_serial_compare_ctrl_pkg::*;
(
  input  logic [NIB_BITS-1:0] a_i,
  input  logic [NIB_BITS-1:0] b_i,
  output logic                eq_o,
  output logic                gt_o,
  output logic                lt_o
);

  assign gt_o = (a_i > b_i);
  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/nibble_serial_compare_ctrl.sv
// Compares two WIDTH-bit unsigned operands one nibble per cycle, starting at the
// MSB, and stops at the first unequal nibble.
// Latency: out_valid rises k+1 cycles after the accept edge, where k is the
// first differing nibble (or NIB-1 if all nibbles are equal).
// Backpressure: the result is held in DONE until out_ready is high. in_ready
// stays low from accept until the result handshake completes.
// Ports: clk, rst_n (async, active-low); bus = slave side of
// nibble_serial_compare_ctrl_if.
module nibble_serial_compare_ctrl
  import nibble_serial_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_serial_compare_ctrl_if.slave bus
);

  localparam int              NIB  = WIDTH / NIB_BITS;
  localparam int              CW   = cnt_width(NIB);
  localparam logic [CW-1:0]   LAST = CW'(NIB - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  res_t             res_q,   res_d;
  // Low during reset and high from the first clock after release. It keeps
  // in_ready low while rst_n is asserted, even though the state is IDLE.
  logic             alive_q;

  // ---------------------------------------------------------------------------
  // Compare slice: it always looks at the top nibble of the shift registers.
  // ---------------------------------------------------------------------------
  logic [NIB_BITS-1:0] a_nib;
  logic [NIB_BITS-1:0] b_nib;
  logic                s_eq;
  logic                s_gt;
  logic                s_lt;

  assign a_nib = a_q[WIDTH-1 -: NIB_BITS];
  assign b_nib = b_q[WIDTH-1 -: NIB_BITS];

  nibble_cmp4 u_cmp (
    .a_i  (a_nib),
    .b_i  (b_nib),
    .eq_o (s_eq),
    .gt_o (s_gt),
    .lt_o (s_lt)
  );

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  logic in_ready_c;
  logic out_valid_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready_c = alive_q;
        if (bus.in_valid && alive_q) begin
          a_d     = bus.A;
          b_d     = bus.B;
          cnt_d   = '0;
          state_d = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        if (!s_eq) begin
          // The first unequal nibble decides the whole comparison.
          res_d   = '{gt: s_gt, eq: 1'b0, lt: s_lt};
          state_d = ST_DONE;
        end else if (cnt_q == LAST) begin
          res_d   = RES_EQ;
          state_d = ST_DONE;
        end else begin
          a_d   = a_q << NIB_BITS;
          b_d   = b_q << NIB_BITS;
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= RES_NONE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      alive_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The flags come straight from the result register, so they keep
  // the last result after the DONE->IDLE handshake.
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.A_gt_B    = res_q.gt;
  assign bus.A_eq_B    = res_q.eq;
  assign bus.A_lt_B    = res_q.lt;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_result_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
      (state_q == ST_DONE) |-> $onehot(res_q)
  );

  a_result_stable_in_done: assert property (
    @(posedge clk) disable iff (!rst_n)
      (state_q == ST_DONE && $past(state_q) == ST_DONE) |-> $stable(res_q)
  );

  a_cnt_in_range: assert property (
    @(posedge clk) disable iff (!rst_n)
      (state_q == ST_COMPARE) |-> (cnt_q <= LAST)
  );

endmodule

// File: tb/tb_nibble_serial_compare_ctrl.sv
// Self-checking bench for nibble_serial_compare_ctrl at WIDTH = 16.
// The reference model computes flags with plain integer compares and latency
// from the first differing nibble.
module tb_nibble_serial_compare_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  nibble_serial_compare_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected {gt, eq, lt} and cycles from accept to out_valid.
  function automatic void ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [2:0] flags, output int lat);
    int na, nb;
    flags = {a > b, a == b, a < b};
    lat   = NIB;
    // Scanning from LSB to MSB leaves the MSB-most difference as the answer.
    for (int i = NIB - 1; i >= 0; i--) begin
      na = int'((a >> (4 * (NIB - 1 - i))) & 16'hF);
      nb = int'((b >> (4 * (NIB - 1 - i))) & 16'hF);
      if (na != nb) lat = i + 1;
    end
  endfunction

  function automatic logic [2:0] flags_now();
    return {bus.A_gt_B, bus.A_eq_B, bus.A_lt_B};
  endfunction

  // Runs one operation from IDLE and leaves the bench at posedge+1 in IDLE.
  // hold is the number of extra DONE cycles with out_ready low.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int hold);
    logic [2:0] exp_f;
    int         exp_lat;
    int         lat;
    int         n;
    ref_model(a, b, exp_f, exp_lat);
    bus.A         = a;
    bus.B         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    n = 0;
    while (!bus.in_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk_val({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;                          // accept edge has passed
    // Disturb the inputs; the captured operands must be the only ones used.
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.A        = 16'hFFFF;
    bus.B        = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 2 * NIB) begin
      chk_val({tag, "/busy_cmp"}, {30'd0, bus.busy, bus.in_ready}, 32'b10);
      @(posedge clk); #1;
      lat++;
      bus.A = 16'h0000;
    end
    chk_val({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk_val({tag, "/flags"}, 32'(flags_now()), 32'(exp_f));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk_val({tag, "/hold"}, {26'd0, bus.out_valid, bus.in_ready, bus.busy, flags_now()},
              {26'd0, 1'b1, 1'b0, 1'b1, exp_f});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk_val({tag, "/idle"}, {26'd0, bus.out_valid, bus.in_ready, bus.busy, flags_now()},
            {26'd0, 1'b0, 1'b1, 1'b0, exp_f});
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int               k, s;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_val("reset_outs", {26'd0, bus.in_ready, bus.out_valid, bus.busy, flags_now()}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_val("post_reset", {29'd0, bus.in_ready, bus.busy, bus.out_valid}, 32'b100);

    run_op("eq_1234",   16'h1234, 16'h1234, 0);
    run_op("gt_9000",   16'h9000, 16'h8FFF, 0);
    run_op("lt_12A4",   16'h12A4, 16'h12B0, 0);
    run_op("bp_0001",   16'h0001, 16'h0000, 5);
    run_op("capt_00F0", 16'h00F0, 16'h00F1, 0);

    // Reset pulse in the middle of a 4-nibble compare.
    bus.A         = 16'h5555;
    bus.B         = 16'h5556;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk_val("mid_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_val("mid_reset_outs", {26'd0, bus.in_ready, bus.out_valid, bus.busy, flags_now()}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    n_quiet();
    run_op("post_rst_0003", 16'h0003, 16'h0003, 0);

    // Random operands, with the first differing nibble chosen deliberately.
    for (int t = 0; t < 40; t++) begin
      ra = 16'($urandom);
      k  = $urandom_range(0, NIB);
      rb = ra;
      if (k < NIB) begin
        s = 4 * (NIB - 1 - k);
        rb[s +: 4] = ra[s +: 4] ^ 4'($urandom_range(1, 15));
        for (int j = 0; j < s; j++) rb[j] = 1'($urandom_range(0, 1));
      end
      run_op("rand", ra, rb, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // After the aborted operation: no result appears, and the controller is
  // ready again.
  task automatic n_quiet();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk_val("no_result_after_abort", {30'd0, seen, bus.in_ready}, 32'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
